// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the cache bus and the memory arbiter.
//   word_t      : one 32-bit bus word
//   ramstate_t  : status reported by the single-ported RAM
//   arb_state_t : arbitration state of memory_arbiter
//   idx_w()     : width of an index into a set of n ports (at least 1 bit)
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DGNT = 2'd1,
        IGNT = 2'd2
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Round-robin selector over a request vector. The search starts at prio_i and
// walks upward (wrapping), so prio_i wins any tie it takes part in.
//   req_i   [CPUS-1:0] request per port
//   prio_i  [IW-1:0]   favoured port index
//   valid_o            at least one request present
//   idx_o   [IW-1:0]   winning port index (0 when valid_o=0)
// -----------------------------------------------------------------------------
module rr_picker
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2,
    parameter int IW   = idx_w(CPUS)
) (
    input  logic [CPUS-1:0] req_i,
    input  logic [IW-1:0]   prio_i,
    output logic            valid_o,
    output logic [IW-1:0]   idx_o
);

    always_comb begin
        logic          found;
        logic [IW-1:0] cand;
        found   = 1'b0;
        cand    = '0;
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = 0; k < CPUS; k++) begin
            // Modulo keeps the candidate in range for non-power-of-two CPUS.
            cand = IW'((int'(prio_i) + k) % CPUS);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
// Memory-side responder for the cache bus. Arbitrates word requests from the
// per-core icache and dcache ports onto one single-ported RAM, holds a dcache
// grant for as long as that dcache keeps a strobe up (writeback then fill),
// and returns RAM data / wait status to the granted port only.
//
//   CLK, nRST                clock (rising edge), async active-low reset
//   iREN, iaddr              icache read request / word address, per core
//   iwait, iload             icache stall (0 on delivery cycle) / data
//   dREN, dWEN, daddr, dstore dcache read / write request, address, data
//   dwait, dload             dcache stall (0 on completion cycle) / data
//   ramREN, ramWEN           RAM strobes
//   ramaddr, ramstore        RAM address / write data
//   ramload, ramstate        RAM read data / status (FREE,BUSY,ACCESS,ERROR)
//
// All outputs are combinational from the registered state, the granted
// port's inputs and ramstate.
//
// state | meaning
// IDLE  | no grant; arbitrate this cycle, no RAM strobes
// DGNT  | dcache[gnt] owns the RAM while dREN|dWEN stays high
// IGNT  | icache[gnt] owns the RAM until ACCESS or iREN drops
// -----------------------------------------------------------------------------
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic [CPUS-1:0]              iREN,
    input  logic [CPUS-1:0][WORD_W-1:0]  iaddr,
    output logic [CPUS-1:0]              iwait,
    output logic [CPUS-1:0][WORD_W-1:0]  iload,
    input  logic [CPUS-1:0]              dREN,
    input  logic [CPUS-1:0]              dWEN,
    input  logic [CPUS-1:0][WORD_W-1:0]  daddr,
    input  logic [CPUS-1:0][WORD_W-1:0]  dstore,
    output logic [CPUS-1:0]              dwait,
    output logic [CPUS-1:0][WORD_W-1:0]  dload,
    output logic                         ramREN,
    output logic                         ramWEN,
    output logic [WORD_W-1:0]            ramaddr,
    output logic [WORD_W-1:0]            ramstore,
    input  logic [WORD_W-1:0]            ramload,
    input  logic [1:0]                   ramstate
);

    localparam int IW = idx_w(CPUS);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [IW-1:0] prio_q, prio_d;

    logic          d_valid, i_valid;
    logic [IW-1:0] d_idx, i_idx;
    logic [IW-1:0] prio_after_gnt;
    logic          ram_done;

    assign ram_done       = (ramstate_t'(ramstate) == ACCESS);
    assign prio_after_gnt = IW'((int'(gnt_q) + 1) % CPUS);

    // A write strobe wins over a read strobe on the same dcache, so both
    // count as a dcache request.
    rr_picker #(.CPUS(CPUS), .IW(IW)) u_pick_d (
        .req_i   (dREN | dWEN),
        .prio_i  (prio_q),
        .valid_o (d_valid),
        .idx_o   (d_idx)
    );

    rr_picker #(.CPUS(CPUS), .IW(IW)) u_pick_i (
        .req_i   (iREN),
        .prio_i  (prio_q),
        .valid_o (i_valid),
        .idx_o   (i_idx)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            prio_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            prio_q  <= prio_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        prio_d   = prio_q;
        iwait    = '1;
        iload    = '0;
        dwait    = '1;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;

        unique case (state_q)
            IDLE: begin
                // Any dcache request beats any icache request.
                if (d_valid) begin
                    state_d = DGNT;
                    gnt_d   = d_idx;
                end else if (i_valid) begin
                    state_d = IGNT;
                    gnt_d   = i_idx;
                end
            end

            DGNT: begin
                if (dREN[gnt_q] || dWEN[gnt_q]) begin
                    // Grant is held across word boundaries and across a
                    // WEN->REN switch; the cache decides when it is done.
                    ramWEN       = dWEN[gnt_q];
                    ramREN       = dREN[gnt_q] & ~dWEN[gnt_q];
                    ramaddr      = daddr[gnt_q];
                    ramstore     = dstore[gnt_q];
                    dwait[gnt_q] = ~ram_done;
                    dload[gnt_q] = ramload;
                end else begin
                    // Release cycle: no strobe, pass priority on.
                    state_d = IDLE;
                    prio_d  = prio_after_gnt;
                end
            end

            IGNT: begin
                if (iREN[gnt_q]) begin
                    ramREN       = 1'b1;
                    ramaddr      = iaddr[gnt_q];
                    iwait[gnt_q] = ~ram_done;
                    iload[gnt_q] = ramload;
                    if (ram_done) begin
                        state_d = IDLE;
                        prio_d  = prio_after_gnt;
                    end
                end else begin
                    // Fetch abandoned before delivery; the core keeps its
                    // round-robin turn.
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int CPUS = 2;

    logic                        CLK;
    logic                        nRST;
    logic [CPUS-1:0]             iREN;
    logic [CPUS-1:0][31:0]       iaddr;
    logic [CPUS-1:0]             iwait;
    logic [CPUS-1:0][31:0]       iload;
    logic [CPUS-1:0]             dREN;
    logic [CPUS-1:0]             dWEN;
    logic [CPUS-1:0][31:0]       daddr;
    logic [CPUS-1:0][31:0]       dstore;
    logic [CPUS-1:0]             dwait;
    logic [CPUS-1:0][31:0]       dload;
    logic                        ramREN;
    logic                        ramWEN;
    word_t                       ramaddr;
    word_t                       ramstore;
    word_t                       ramload;
    ramstate_t                   ramstate;

    memory_arbiter #(.CPUS(CPUS)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- RAM model: fixed latency, optional forced ERROR -------
    int lat        = 1;
    bit force_err  = 1'b0;
    int cnt        = 0;
    int wr_commits = 0;

    function automatic word_t rd_word(input word_t a);
        return (a == 32'h40) ? 32'hDEAD_BEEF : {16'hC0DE, a[15:0]};
    endfunction

    always_comb begin
        ramstate = FREE;
        ramload  = '0;
        if (ramREN || ramWEN) begin
            if (force_err)          ramstate = ERROR;
            else if (cnt >= lat-1)  ramstate = ACCESS;
            else                    ramstate = BUSY;
        end
        if (ramstate == ACCESS && ramREN) ramload = rd_word(ramaddr);
    end

    always @(posedge CLK) begin
        if ((ramREN || ramWEN) && ramstate != ACCESS) begin
            if (!force_err) cnt <= cnt + 1;
        end else begin
            cnt <= 0;
        end
        if (ramWEN && ramstate == ACCESS) wr_commits <= wr_commits + 1;
    end

    // ---------------- scoreboard -------------------------------------------
    typedef struct {
        bit    is_d;
        int    port;
        bit    wr;
        word_t addr;
        word_t data;
    } exp_t;

    exp_t sb[$];

    function automatic void push(input bit is_d, input int port, input bit wr,
                                 input word_t a, input word_t d);
        exp_t e;
        e.is_d = is_d;
        e.port = port;
        e.wr   = wr;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endfunction

    task automatic sb_check(input bit is_d, input int c);
        exp_t e;
        chk("sb_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_who", 64'({is_d, 32'(c)}), 64'({e.is_d, 32'(e.port)}));
            chk("sb_addr", 64'(ramaddr), 64'(e.addr));
            if (e.wr) begin
                chk("sb_wen", 64'(ramWEN), 64'd1);
                chk("sb_wstore", 64'(ramstore), 64'(e.data));
            end else begin
                chk("sb_load", is_d ? 64'(dload[c]) : 64'(iload[c]), 64'(e.data));
            end
        end
    endtask

    bit burst_active = 1'b0;
    int burst_viol   = 0;

    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            for (int c = 0; c < CPUS; c++) begin
                if (iwait[c] === 1'b0) sb_check(1'b0, c);
                if (dwait[c] === 1'b0) sb_check(1'b1, c);
            end
            if (burst_active && ramREN && ramaddr == iaddr[1]) burst_viol++;
        end
    end

    // ---------------- helpers -----------------------------------------------
    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_done(input bit is_d, input int c, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (is_d ? (dwait[c] === 1'b0) : (iwait[c] === 1'b0)) begin
                done = 1'b1;
                break;
            end
            nxt();
        end
        chk(is_d ? "d_done" : "i_done", 64'(done), 64'd1);
    endtask

    task automatic rr_drv(input int c, input word_t a);
        daddr[c] = a;
        for (int w = 0; w < 2; w++) begin
            dREN[c] = 1'b1;
            wait_done(1'b1, c, 12);
            nxt();
            dREN[c] = 1'b0;
            nxt();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence -------------------------------------
    initial begin
        int saved;
        bit seen;

        // Reset with arbitrary inputs
        nRST   = 1'b0;
        iREN   = '1;
        dREN   = '1;
        dWEN   = 2'b01;
        iaddr  = {32'h1234_5678, 32'h0000_00F0};
        daddr  = {32'h0000_0300, 32'h0000_0304};
        dstore = {32'hAAAA_AAAA, 32'h5555_5555};
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_iwait", 64'(iwait), 64'h3);
        chk("rst_dwait", 64'(dwait), 64'h3);
        chk("rst_ren", 64'(ramREN), 64'd0);
        chk("rst_wen", 64'(ramWEN), 64'd0);
        chk("rst_addr", 64'(ramaddr), 64'd0);
        chk("rst_store", 64'(ramstore), 64'd0);
        chk("rst_iload", 64'(iload[0] | iload[1]), 64'd0);
        chk("rst_dload", 64'(dload[0] | dload[1]), 64'd0);
        nxt();
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        nRST = 1'b1;
        nxt();

        // Single icache read, RAM ACCESS on 2nd RAM cycle
        lat = 2;
        iREN[0]  = 1'b1;
        iaddr[0] = 32'h40;
        push(1'b0, 0, 1'b0, 32'h40, 32'hDEAD_BEEF);
        @(negedge CLK);
        chk("t2_arb_ren", 64'(ramREN), 64'd0);
        chk("t2_arb_iwait", 64'(iwait[0]), 64'd1);
        nxt();
        @(negedge CLK);
        chk("t2_c1_ren", 64'(ramREN), 64'd1);
        chk("t2_c1_addr", 64'(ramaddr), 64'h40);
        chk("t2_c1_iwait", 64'(iwait[0]), 64'd1);
        nxt();
        @(negedge CLK);
        chk("t2_iwait", 64'(iwait[0]), 64'd0);
        chk("t2_iload", 64'(iload[0]), 64'hDEAD_BEEF);
        chk("t2_other_iwait", 64'(iwait[1]), 64'd1);
        nxt();
        iREN[0] = 1'b0;
        @(negedge CLK);
        chk("t2_idle", 64'(dut.state_q), 64'(IDLE));
        chk("t2_idle_ren", 64'(ramREN), 64'd0);
        nxt();

        // dcache beats icache on the same cycle
        lat = 1;
        iREN[0]  = 1'b1;
        iaddr[0] = 32'h48;
        dREN[1]  = 1'b1;
        daddr[1] = 32'h200;
        push(1'b1, 1, 1'b0, 32'h200, 32'hC0DE_0200);
        push(1'b0, 0, 1'b0, 32'h48,  32'hC0DE_0048);
        wait_done(1'b1, 1, 8);
        chk("t3_iwait_held", 64'(iwait[0]), 64'd1);
        nxt();
        dREN[1] = 1'b0;
        @(negedge CLK);
        chk("t3_release_ren", 64'(ramREN), 64'd0);
        chk("t3_release_iwait", 64'(iwait[0]), 64'd1);
        nxt();
        wait_done(1'b0, 0, 8);
        nxt();
        iREN[0] = 1'b0;

        // Held dcache burst: WB 0x100, 0x104, fill 0x200, 0x204; icache 1 waits
        lat = 2;
        iREN[1]  = 1'b1;
        iaddr[1] = 32'h3C0;
        burst_active = 1'b1;
        dWEN[0]   = 1'b1;
        daddr[0]  = 32'h100;
        dstore[0] = 32'h1111_1111;
        push(1'b1, 0, 1'b1, 32'h100, 32'h1111_1111);
        wait_done(1'b1, 0, 10);
        chk("t4_iwait1_w0", 64'(iwait[1]), 64'd1);
        nxt();
        daddr[0]  = 32'h104;
        dstore[0] = 32'h2222_2222;
        push(1'b1, 0, 1'b1, 32'h104, 32'h2222_2222);
        wait_done(1'b1, 0, 10);
        chk("t4_iwait1_w1", 64'(iwait[1]), 64'd1);
        nxt();
        dWEN[0]  = 1'b0;
        dREN[0]  = 1'b1;
        daddr[0] = 32'h200;
        push(1'b1, 0, 1'b0, 32'h200, 32'hC0DE_0200);
        wait_done(1'b1, 0, 10);
        chk("t4_iwait1_r0", 64'(iwait[1]), 64'd1);
        nxt();
        daddr[0] = 32'h204;
        push(1'b1, 0, 1'b0, 32'h204, 32'hC0DE_0204);
        wait_done(1'b1, 0, 10);
        chk("t4_iwait1_r1", 64'(iwait[1]), 64'd1);
        nxt();
        dREN[0] = 1'b0;
        burst_active = 1'b0;
        chk("t4_no_ifetch_in_burst", 64'(burst_viol), 64'd0);
        push(1'b0, 1, 1'b0, 32'h3C0, 32'hC0DE_03C0);
        wait_done(1'b0, 1, 10);
        nxt();
        iREN[1] = 1'b0;

        // Round robin between two dcaches (prio reset to 0 first)
        nRST = 1'b0;
        nxt();
        nRST = 1'b1;
        lat = 1;
        push(1'b1, 0, 1'b0, 32'h010, 32'hC0DE_0010);
        push(1'b1, 1, 1'b0, 32'h020, 32'hC0DE_0020);
        push(1'b1, 0, 1'b0, 32'h010, 32'hC0DE_0010);
        push(1'b1, 1, 1'b0, 32'h020, 32'hC0DE_0020);
        fork
            rr_drv(0, 32'h010);
            rr_drv(1, 32'h020);
        join
        chk("t5_sb_drained", 64'(sb.size()), 64'd0);

        // ERROR for 3 cycles, then ACCESS
        lat = 1;
        dREN[0]  = 1'b1;
        daddr[0] = 32'h044;
        push(1'b1, 0, 1'b0, 32'h044, 32'hC0DE_0044);
        @(negedge CLK);
        nxt();
        force_err = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("t6_err_dwait", 64'(dwait[0]), 64'd1);
            chk("t6_err_ren", 64'(ramREN), 64'd1);
            chk("t6_err_addr", 64'(ramaddr), 64'h044);
            nxt();
        end
        force_err = 1'b0;
        @(negedge CLK);
        chk("t6_after_err_dwait", 64'(dwait[0]), 64'd0);
        nxt();
        dREN[0] = 1'b0;

        // Reset pulsed in the middle of a RAM write
        lat = 3;
        saved = wr_commits;
        dWEN[1]   = 1'b1;
        daddr[1]  = 32'h0F0;
        dstore[1] = 32'h55AA_55AA;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (ramWEN === 1'b1) begin
                seen = 1'b1;
                break;
            end
            nxt();
        end
        chk("t6_write_started", 64'(seen), 64'd1);
        nxt();
        nRST = 1'b0;
        #1;
        chk("t6_abort_wen", 64'(ramWEN), 64'd0);
        chk("t6_abort_state", 64'(dut.state_q), 64'(IDLE));
        chk("t6_abort_dwait", 64'(dwait), 64'h3);
        dWEN[1] = 1'b0;
        nxt();
        nRST = 1'b1;
        nxt();
        @(negedge CLK);
        chk("t6_no_write_commit", 64'(wr_commits), 64'(saved));
        chk("sb_final_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
